// File: rtl/adpcm_rom_fetch.sv
// Two-line read cache between the ADPCM engine's byte-wide sample ROM port
// and a 64-bit external memory; misses fetch one aligned 8-byte line at a time.
module adpcm_rom_fetch #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MEM_ADDR_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [17:0]               io_rom_addr,
    output logic [7:0]                io_rom_dout,
    output logic                      io_rom_valid,
    output logic                      io_mem_rd,
    output logic [MEM_ADDR_WIDTH-1:0] io_mem_addr,
    input  logic                      io_mem_waitReq,
    input  logic                      io_mem_valid,
    input  logic [63:0]               io_mem_dout
);

    localparam logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR_W = MEM_ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [1:0]                line_valid;
    logic [14:0]               line_tag  [2];
    logic [63:0]               line_data [2];
    logic                      lru;
    logic [14:0]               fetch_tag;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;

    logic [14:0] req_tag;
    logic [1:0]  hit_way;
    logic [1:0]  fill_match;
    logic        hit;
    logic        hit_idx;
    logic        fill_idx;
    logic        fill_en;
    logic        start_fetch;
    logic [63:0] hit_line;

    assign req_tag = io_rom_addr[17:3];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hit_way[i]    = line_valid[i] && (line_tag[i] == req_tag);
            fill_match[i] = line_valid[i] && (line_tag[i] == fetch_tag);
        end
    end

    assign hit      = |hit_way;
    assign hit_idx  = hit_way[1];
    assign hit_line = line_data[hit_idx];
    // A fill whose tag is already resident overwrites that entry, never a duplicate.
    assign fill_idx = (|fill_match) ? fill_match[1] : lru;

    assign io_rom_valid = hit;
    assign io_rom_dout  = hit ? hit_line[{io_rom_addr[2:0], 3'b000} +: 8] : 8'h00;
    assign io_mem_addr  = mem_addr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        io_mem_rd   = 1'b0;
        fill_en     = 1'b0;
        start_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    start_fetch = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                io_mem_rd = 1'b1;
                if (!io_mem_waitReq) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (io_mem_valid) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A fill takes precedence over a same-cycle hit when steering the LRU bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_valid <= 2'b00;
            lru        <= 1'b0;
            fetch_tag  <= '0;
            mem_addr_q <= BASE_ADDR_W;
        end else begin
            if (start_fetch) begin
                fetch_tag  <= req_tag;
                mem_addr_q <= BASE_ADDR_W + MEM_ADDR_WIDTH'({req_tag, 3'b000});
            end
            if (fill_en) begin
                line_valid[fill_idx] <= 1'b1;
                lru                  <= ~fill_idx;
            end else if (hit) begin
                lru <= ~hit_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            line_tag[fill_idx]  <= fetch_tag;
            line_data[fill_idx] <= io_mem_dout;
        end
    end

endmodule

// File: tb/tb_adpcm_rom_fetch.sv
// Bench for adpcm_rom_fetch: a line-level cache model plus a latency-modelled
// memory responder, directed scenarios and a randomized run.
`timescale 1ns/1ps
module tb_adpcm_rom_fetch;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] io_rom_addr = 18'h0;
    logic [7:0]  io_rom_dout;
    logic        io_rom_valid;
    logic        io_mem_rd;
    logic [31:0] io_mem_addr;
    logic        io_mem_waitReq = 1'b0;
    logic        io_mem_valid = 1'b0;
    logic [63:0] io_mem_dout = 64'h0;

    always #5 clock = ~clock;

    adpcm_rom_fetch #(
        .BASE_ADDR(BASE),
        .MEM_ADDR_WIDTH(32)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .io_rom_addr(io_rom_addr),
        .io_rom_dout(io_rom_dout),
        .io_rom_valid(io_rom_valid),
        .io_mem_rd(io_mem_rd),
        .io_mem_addr(io_mem_addr),
        .io_mem_waitReq(io_mem_waitReq),
        .io_mem_valid(io_mem_valid),
        .io_mem_dout(io_mem_dout)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off == 32'h0) return 64'h8877665544332211;
        return {off ^ 32'hC3A5_5A3C, off * 32'h9E37_79B1 + 32'h1};
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] w, input logic [2:0] b);
        return w[{b, 3'b000} +: 8];
    endfunction

    // Memory responder: one pending read, fixed or random latency, optional
    // back-pressure and stray valid pulses when nothing is pending.
    int          cyc = 0, accepts = 0, rd_cycles = 0, addr_changes = 0;
    int          stall_left = 0, lat_cfg = 3, pend_cnt = 0, valid_cyc = -10;
    bit          rand_mode = 1'b0;
    logic [31:0] pend_addr = 32'h0, prev_addr = 32'h0;
    bit          prev_rd = 1'b0;

    always @(posedge clock) begin
        bit          fire;
        bit          spur;
        logic [63:0] fire_data;
        fire = 1'b0;
        fire_data = 64'h0;
        cyc++;
        if (io_mem_rd && prev_rd && io_mem_addr != prev_addr) addr_changes++;
        prev_rd = io_mem_rd;
        prev_addr = io_mem_addr;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                fire = 1'b1;
                fire_data = mem_word(pend_addr);
            end
        end
        if (io_mem_rd) begin
            rd_cycles++;
            if (io_mem_waitReq) begin
                if (stall_left > 0) stall_left--;
            end else begin
                accepts++;
                pend_addr = io_mem_addr;
                pend_cnt = rand_mode ? int'($urandom_range(1, 5)) : lat_cfg;
            end
        end
        spur = rand_mode && !fire && pend_cnt == 0 && $urandom_range(0, 7) == 0;
        #1;
        io_mem_valid = fire || spur;
        io_mem_dout = fire ? fire_data : {$urandom, $urandom};
        io_mem_waitReq = (stall_left > 0) || (rand_mode && $urandom_range(0, 3) == 0);
        if (fire) valid_cyc = cyc;
    end

    // Reference model: cache contents as tagged lines, plus whether a fetch is
    // being requested or its data awaited.
    bit          m_valid [2] = '{1'b0, 1'b0};
    logic [14:0] m_tag   [2];
    logic [63:0] m_data  [2];
    bit          m_lru = 1'b0;
    bit          requesting = 1'b0, awaiting = 1'b0;
    logic [14:0] m_fetch_tag = 15'h0;
    logic [31:0] m_mem_addr = BASE;
    int          mh, mv;
    bit          midle;

    function automatic int find(input logic [14:0] t);
        for (int i = 0; i < 2; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            m_lru = 1'b0;
            requesting = 1'b0;
            awaiting = 1'b0;
            m_mem_addr = BASE;
        end else begin
            mh = find(io_rom_addr[17:3]);
            midle = !requesting && !awaiting;
            if (awaiting && io_mem_valid) begin
                mv = find(m_fetch_tag);
                if (mv < 0) mv = int'(m_lru);
                m_valid[mv] = 1'b1;
                m_tag[mv] = m_fetch_tag;
                m_data[mv] = io_mem_dout;
                m_lru = (mv == 0);
                awaiting = 1'b0;
            end else if (mh >= 0) begin
                m_lru = (mh == 0);
            end
            if (requesting) begin
                if (!io_mem_waitReq) begin
                    requesting = 1'b0;
                    awaiting = 1'b1;
                end
            end else if (midle && mh < 0) begin
                m_fetch_tag = io_rom_addr[17:3];
                m_mem_addr = BASE + {14'h0, io_rom_addr[17:3], 3'b000};
                requesting = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        int h;
        if (check_en) begin
            h = find(io_rom_addr[17:3]);
            checkOutput("model_rom_valid", 64'(io_rom_valid), 64'(h >= 0));
            checkOutput("model_rom_dout", 64'(io_rom_dout),
                        (h >= 0) ? 64'(byte_of(m_data[h], io_rom_addr[2:0])) : 64'h0);
            checkOutput("model_mem_rd", 64'(io_mem_rd), 64'(requesting));
            checkOutput("model_mem_addr", 64'(io_mem_addr), 64'(m_mem_addr));
        end
    end

    task automatic applyStimulus(input logic [17:0] a);
        @(posedge clock);
        #1;
        io_rom_addr = a;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (!io_rom_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput({name, "_valid"}, 64'(io_rom_valid), 64'h1);
    endtask

    task automatic waitAccept(input int base_cnt, input string name);
        int n;
        n = 0;
        while (accepts == base_cnt && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput({name, "_accept"}, 64'(accepts), 64'(base_cnt + 1));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          a0, a1, r0, c0;
        logic [63:0] line0;
        logic [63:0] w48;
        line0 = 64'h8877665544332211;
        io_rom_addr = 18'h00005;

        @(posedge clock);
        #1 check_en = 1'b1;
        @(negedge clock);
        checkOutput("rst_valid", 64'(io_rom_valid), 64'h0);
        checkOutput("rst_dout", 64'(io_rom_dout), 64'h0);
        checkOutput("rst_rd", 64'(io_mem_rd), 64'h0);
        checkOutput("rst_mem_addr", 64'(io_mem_addr), 64'(BASE));

        // Cold miss on a byte inside line 0.
        a0 = accepts;
        r0 = rd_cycles;
        @(posedge clock);
        #1 reset_n = 1'b1;
        waitValid("cold");
        checkOutput("cold_dout", 64'(io_rom_dout), 64'h66);
        checkOutput("cold_rise", 64'(cyc), 64'(valid_cyc + 1));
        checkOutput("cold_accepts", 64'(accepts - a0), 64'h1);
        checkOutput("cold_rd_cycles", 64'(rd_cycles - r0), 64'h1);
        checkOutput("cold_mem_addr", 64'(io_mem_addr), 64'(BASE));

        // Every byte of the resident line hits with no further reads.
        a0 = accepts;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(18'(i));
            @(negedge clock);
            checkOutput("hit_valid", 64'(io_rom_valid), 64'h1);
            checkOutput("hit_dout", 64'(io_rom_dout), 64'(line0[8*i +: 8]));
        end
        checkOutput("hit_no_rd", 64'(accepts - a0), 64'h0);

        // LRU victim selection.
        applyStimulus(18'h00008);
        waitValid("lru_fill8");
        applyStimulus(18'h00000);
        @(negedge clock);
        checkOutput("lru_touch0", 64'(io_rom_valid), 64'h1);
        applyStimulus(18'h00010);
        waitValid("lru_fill16");
        applyStimulus(18'h00000);
        @(negedge clock);
        checkOutput("lru_keep0", 64'(io_rom_valid), 64'h1);
        applyStimulus(18'h00008);
        @(negedge clock);
        checkOutput("lru_evict8", 64'(io_rom_valid), 64'h0);
        waitValid("lru_refill8");

        // Back-pressure: four refused cycles before acceptance.
        stall_left = 4;
        @(negedge clock);
        a0 = accepts;
        r0 = rd_cycles;
        c0 = addr_changes;
        applyStimulus(18'h00018);
        waitValid("bp");
        checkOutput("bp_rd_cycles", 64'(rd_cycles - r0), 64'h5);
        checkOutput("bp_accepts", 64'(accepts - a0), 64'h1);
        checkOutput("bp_addr_stable", 64'(addr_changes - c0), 64'h0);
        checkOutput("bp_mem_addr", 64'(io_mem_addr), 64'(BASE + 32'h18));

        // Address moves while the first fetch is awaiting data.
        a0 = accepts;
        applyStimulus(18'h00020);
        waitAccept(a0, "mid1");
        applyStimulus(18'h00040);
        waitAccept(a0 + 1, "mid2");
        checkOutput("mid2_mem_addr", 64'(io_mem_addr), 64'(BASE + 32'h40));
        checkOutput("mid2_valid_low", 64'(io_rom_valid), 64'h0);
        waitValid("mid_fill40");
        checkOutput("mid_accepts", 64'(accepts - a0), 64'h2);
        applyStimulus(18'h00020);
        @(negedge clock);
        checkOutput("mid_keep20", 64'(io_rom_valid), 64'h1);

        // Reset while awaiting data; the stale response must be dropped.
        a0 = accepts;
        applyStimulus(18'h00048);
        waitAccept(a0, "rstmid");
        stall_left = 8;
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        checkOutput("rstmid_valid", 64'(io_rom_valid), 64'h0);
        checkOutput("rstmid_rd", 64'(io_mem_rd), 64'h0);
        checkOutput("rstmid_mem_addr", 64'(io_mem_addr), 64'(BASE));
        @(posedge clock);
        #1 reset_n = 1'b1;
        a1 = accepts;
        @(negedge clock);
        checkOutput("rel_valid", 64'(io_rom_valid), 64'h0);
        checkOutput("rel_mem_addr", 64'(io_mem_addr), 64'(BASE));
        repeat (3) @(negedge clock);
        checkOutput("late_ignored", 64'(io_rom_valid), 64'h0);
        waitValid("rst_refetch");
        w48 = mem_word(BASE + 32'h48);
        checkOutput("rst_refetch_accepts", 64'(accepts - a1), 64'h1);
        checkOutput("rst_refetch_addr", 64'(io_mem_addr), 64'(BASE + 32'h48));
        checkOutput("rst_refetch_dout", 64'(io_rom_dout), 64'(w48[7:0]));

        // Randomized traffic over a small tag pool including the top tag.
        rand_mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(posedge clock);
            #1;
            if ($urandom_range(0, 2) == 0) begin
                logic [14:0] t;
                t = ($urandom_range(0, 5) == 5) ? 15'h7FFF : 15'($urandom_range(0, 4));
                io_rom_addr = {t, 3'($urandom_range(0, 7))};
            end
        end
        rand_mode = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
